// File: rtl/jt12_opmod_pkg.sv
// Shared encodings and helpers for the FM operator modulation router.
// Used by jt12_opmod_router; JT12_OPMOD_ACC_EN selects the carrier accumulator.
package jt12_opmod_pkg;

    typedef enum logic [2:0] {
        ALG0 = 3'd0, ALG1 = 3'd1, ALG2 = 3'd2, ALG3 = 3'd3,
        ALG4 = 3'd4, ALG5 = 3'd5, ALG6 = 3'd6, ALG7 = 3'd7
    } alg_e;

    typedef enum logic [1:0] {
        OP0 = 2'd0, OP1 = 2'd1, OP2 = 2'd2, OP3 = 2'd3
    } op_e;

    // Bit n set when operator n is a carrier in the given algorithm.
    function automatic logic [3:0] carrier_mask(input logic [2:0] alg);
        logic [3:0] m;
        case (alg)
            ALG0, ALG1, ALG2, ALG3: m = 4'b1000;
            ALG4:                   m = 4'b1010;
            ALG5, ALG6:             m = 4'b1110;
            default:                m = 4'b1111;
        endcase
        return m;
    endfunction

    // Clamp a signed value to the range of a w-bit two's complement number (w < 64).
    function automatic longint sat_to(input longint v, input int w);
        longint hi;
        longint lo;
        hi = (longint'(1) <<< (w - 1)) - longint'(1);
        lo = -hi - longint'(1);
        if (v > hi)
            return hi;
        else if (v < lo)
            return lo;
        else
            return v;
    endfunction

endpackage

// File: rtl/jt12_opmod_if.sv
// Request/result/output bundle between the operator sequencer (master) and the router (slave).
interface jt12_opmod_if #(
    parameter int NUM_VOICES = 6,
    parameter int OPW        = 14,
    parameter int PHW        = 10,
    parameter int ACCW       = 16
);
    localparam int VW = $clog2(NUM_VOICES);

    logic                   req_valid;
    logic [VW-1:0]          req_voice;
    logic [1:0]             req_op;
    logic [2:0]             req_alg;
    logic [2:0]             req_fb;
    logic [PHW-1:0]         phase_in;
    logic                   res_valid;
    logic [VW-1:0]          res_voice;
    logic [1:0]             res_op;
    logic signed [OPW-1:0]  res_data;
    logic                   mod_valid;
    logic [PHW-1:0]         phase_out;
    logic                   voice_valid;
    logic signed [ACCW-1:0] voice_out;

    modport master (
        output req_valid, req_voice, req_op, req_alg, req_fb, phase_in,
        output res_valid, res_voice, res_op, res_data,
        input  mod_valid, phase_out, voice_valid, voice_out
    );

    modport slave (
        input  req_valid, req_voice, req_op, req_alg, req_fb, phase_in,
        input  res_valid, res_voice, res_op, res_data,
        output mod_valid, phase_out, voice_valid, voice_out
    );
endinterface

// File: rtl/jt12_opmod_mem.sv
// Per-voice operator history: one write port, one registered read port (read sees pre-write data).
module jt12_opmod_mem
    import jt12_opmod_pkg::*;
#(
    parameter int NUM_VOICES = 6,
    parameter int OPW        = 14,
    parameter int VW         = $clog2(NUM_VOICES)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clk_en,
    input  logic                  wr_en,
    input  logic [VW-1:0]         wr_voice,
    input  logic [1:0]            wr_op,
    input  logic signed [OPW-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [VW-1:0]         rd_voice,
    output logic signed [OPW-1:0] rd_h0a,
    output logic signed [OPW-1:0] rd_h0b,
    output logic signed [OPW-1:0] rd_l1,
    output logic signed [OPW-1:0] rd_l2,
    output logic signed [OPW-1:0] rd_l3
);
    localparam logic [VW:0] NV = (VW + 1)'(NUM_VOICES);

    logic signed [OPW-1:0] h0a [NUM_VOICES];
    logic signed [OPW-1:0] h0b [NUM_VOICES];
    logic signed [OPW-1:0] l1  [NUM_VOICES];
    logic signed [OPW-1:0] l2  [NUM_VOICES];
    logic signed [OPW-1:0] l3  [NUM_VOICES];

    logic wr_in;
    logic rd_in;

    assign wr_in = wr_en && ({1'b0, wr_voice} < NV);
    assign rd_in = {1'b0, rd_voice} < NV;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned v = 0; v < NUM_VOICES; v++) begin
                h0a[v] <= '0;
                h0b[v] <= '0;
                l1[v]  <= '0;
                l2[v]  <= '0;
                l3[v]  <= '0;
            end
            rd_h0a <= '0;
            rd_h0b <= '0;
            rd_l1  <= '0;
            rd_l2  <= '0;
            rd_l3  <= '0;
        end else if (clk_en) begin
            if (wr_in) begin
                case (wr_op)
                    OP0: begin
                        h0b[wr_voice] <= h0a[wr_voice];
                        h0a[wr_voice] <= wr_data;
                    end
                    OP1:     l1[wr_voice] <= wr_data;
                    OP2:     l2[wr_voice] <= wr_data;
                    default: l3[wr_voice] <= wr_data;
                endcase
            end
            // Out-of-range voices read as all-zero history, which makes their modulation zero.
            if (rd_en) begin
                rd_h0a <= rd_in ? h0a[rd_voice] : '0;
                rd_h0b <= rd_in ? h0b[rd_voice] : '0;
                rd_l1  <= rd_in ? l1[rd_voice]  : '0;
                rd_l2  <= rd_in ? l2[rd_voice]  : '0;
                rd_l3  <= rd_in ? l3[rd_voice]  : '0;
            end
        end
    end
endmodule

// File: rtl/jt12_opmod_router.sv
// FM modulation router: per-voice history capture and modulated phase per issued slot.
// Define JT12_OPMOD_ACC_EN to add the per-voice carrier accumulator and voice output.
module jt12_opmod_router
    import jt12_opmod_pkg::*;
#(
    parameter int NUM_VOICES = 6,
    parameter int OPW        = 14,
    parameter int PHW        = 10,
    parameter int MOD_SHR    = 1,
    parameter int ACCW       = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_en,
    jt12_opmod_if.slave bus
);
    localparam int VW = $clog2(NUM_VOICES);
    localparam int MW = OPW + 1;
    localparam int WW = (MW > PHW) ? MW : PHW;

    logic signed [OPW-1:0] rd_h0a, rd_h0b, rd_l1, rd_l2, rd_l3;
    logic                  mv_q;
    logic [1:0]            op_q;
    logic [2:0]            alg_q;
    logic [2:0]            fb_q;
    logic [PHW-1:0]        ph_q;

    jt12_opmod_mem #(
        .NUM_VOICES (NUM_VOICES),
        .OPW        (OPW),
        .VW         (VW)
    ) u_mem (
        .clk      (clk),
        .rst      (rst),
        .clk_en   (clk_en),
        .wr_en    (bus.res_valid),
        .wr_voice (bus.res_voice),
        .wr_op    (bus.res_op),
        .wr_data  (bus.res_data),
        .rd_en    (bus.req_valid),
        .rd_voice (bus.req_voice),
        .rd_h0a   (rd_h0a),
        .rd_h0b   (rd_h0b),
        .rd_l1    (rd_l1),
        .rd_l2    (rd_l2),
        .rd_l3    (rd_l3)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            mv_q  <= 1'b0;
            op_q  <= '0;
            alg_q <= '0;
            fb_q  <= '0;
            ph_q  <= '0;
        end else begin
            mv_q <= clk_en && bus.req_valid;
            if (clk_en && bus.req_valid) begin
                op_q  <= bus.req_op;
                alg_q <= bus.req_alg;
                fb_q  <= bus.req_fb;
                ph_q  <= bus.phase_in;
            end
        end
    end

    logic signed [MW-1:0] ea, eb, e1, e2;
    logic signed [MW-1:0] m, madj;
    logic signed [WW-1:0] mw;

    assign ea = MW'(rd_h0a);
    assign eb = MW'(rd_h0b);
    assign e1 = MW'(rd_l1);
    assign e2 = MW'(rd_l2);

    always_comb begin
        m = '0;
        case (op_q)
            OP0: if (fb_q != 3'd0) m = (ea + eb) >>> (4'd10 - {1'b0, fb_q});
            OP1: case (alg_q)
                ALG0, ALG3, ALG4, ALG5, ALG6: m = ea;
                default: m = '0;
            endcase
            OP2: case (alg_q)
                ALG0, ALG2: m = e1;
                ALG1:       m = ea + e1;
                ALG5:       m = ea;
                default:    m = '0;
            endcase
            default: case (alg_q)
                ALG0, ALG1, ALG4: m = e2;
                ALG2:             m = ea + e2;
                ALG3:             m = e1 + e2;
                ALG5:             m = ea;
                default:          m = '0;
            endcase
        endcase
        // Feedback already carries its own (10-fb) scaling, so MOD_SHR applies only to op1..op3.
        madj = (op_q == OP0) ? m : (m >>> MOD_SHR);
        mw   = WW'(madj);
    end

    assign bus.mod_valid = mv_q;
    assign bus.phase_out = ph_q + mw[PHW-1:0];

`ifdef JT12_OPMOD_ACC_EN
    localparam logic [VW:0] NV = (VW + 1)'(NUM_VOICES);

    logic signed [ACCW-1:0] acc  [NUM_VOICES];
    logic [2:0]             valg [NUM_VOICES];
    logic                   vv_q;
    logic signed [ACCW-1:0] vo_q;
    logic                   req_in, res_in;
    logic [3:0]             cmask;
    logic signed [ACCW-1:0] acc_sum;

    assign req_in = bus.req_valid && ({1'b0, bus.req_voice} < NV);
    assign res_in = bus.res_valid && ({1'b0, bus.res_voice} < NV);

    always_comb begin
        cmask   = '0;
        acc_sum = '0;
        if (res_in) begin
            cmask   = carrier_mask(valg[bus.res_voice]);
            acc_sum = ACCW'(sat_to(longint'(acc[bus.res_voice])
                          + (cmask[bus.res_op] ? longint'(bus.res_data) : longint'(0)), ACCW));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned v = 0; v < NUM_VOICES; v++) begin
                acc[v]  <= '0;
                valg[v] <= '0;
            end
            vv_q <= 1'b0;
            vo_q <= '0;
        end else begin
            vv_q <= 1'b0;
            if (clk_en) begin
                if (req_in && bus.req_op == OP0)
                    valg[bus.req_voice] <= bus.req_alg;
                if (res_in) begin
                    if (bus.res_op == OP3) begin
                        vo_q                <= acc_sum;
                        vv_q                <= 1'b1;
                        acc[bus.res_voice]  <= '0;
                    end else begin
                        acc[bus.res_voice]  <= acc_sum;
                    end
                end
            end
        end
    end

    assign bus.voice_valid = vv_q;
    assign bus.voice_out   = vo_q;
`else
    assign bus.voice_valid = 1'b0;
    assign bus.voice_out   = ACCW'(0);
`endif
endmodule

// File: tb/tb_jt12_opmod_router.sv
// Directed self-checking bench for jt12_opmod_router (default parameters; honours JT12_OPMOD_ACC_EN).
module tb_jt12_opmod_router;
    logic clk = 1'b0;
    logic rst;
    logic clk_en;
    int   n_pass  = 0;
    int   n_total = 0;

    jt12_opmod_if #(.NUM_VOICES(6), .OPW(14), .PHW(10), .ACCW(16)) bus ();

    jt12_opmod_router #(
        .NUM_VOICES (6),
        .OPW        (14),
        .PHW        (10),
        .MOD_SHR    (1),
        .ACCW       (16)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .clk_en (clk_en),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_res(input logic [2:0] v, input logic [1:0] op, input logic [13:0] d);
        bus.res_valid = 1'b1;
        bus.res_voice = v;
        bus.res_op    = op;
        bus.res_data  = d;
        tick();
        bus.res_valid = 1'b0;
    endtask

    task automatic do_req(input logic [2:0] v, input logic [1:0] op, input logic [2:0] alg,
                          input logic [2:0] fb, input logic [9:0] ph);
        bus.req_valid = 1'b1;
        bus.req_voice = v;
        bus.req_op    = op;
        bus.req_alg   = alg;
        bus.req_fb    = fb;
        bus.phase_in  = ph;
        tick();
        bus.req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clk_en = 1'b1;
        bus.req_valid = 1'b0; bus.req_voice = '0; bus.req_op = '0; bus.req_alg = '0;
        bus.req_fb = '0; bus.phase_in = '0;
        bus.res_valid = 1'b0; bus.res_voice = '0; bus.res_op = '0; bus.res_data = '0;
        repeat (3) tick();
        n_total++; if (bus.mod_valid !== 1'b0) $display("FAIL reset_mod_valid got %b want 0", bus.mod_valid); else n_pass++;
        n_total++; if (bus.phase_out !== 10'h000) $display("FAIL reset_phase_out got %h want 000", bus.phase_out); else n_pass++;
        n_total++; if (bus.voice_valid !== 1'b0) $display("FAIL reset_voice_valid got %b want 0", bus.voice_valid); else n_pass++;
        n_total++; if (bus.voice_out !== 16'sh0000) $display("FAIL reset_voice_out got %h want 0000", bus.voice_out); else n_pass++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_unmodulated();
        do_req(3'd2, 2'd1, 3'd0, 3'd0, 10'h100);
        n_total++; if (bus.mod_valid !== 1'b1) $display("FAIL unmod_valid got %b want 1", bus.mod_valid); else n_pass++;
        n_total++; if (bus.phase_out !== 10'h100) $display("FAIL unmod_phase got %h want 100", bus.phase_out); else n_pass++;
        tick();
        n_total++; if (bus.mod_valid !== 1'b0) $display("FAIL unmod_pulse got %b want 0", bus.mod_valid); else n_pass++;
        n_total++; if (bus.phase_out !== 10'h100) $display("FAIL unmod_hold got %h want 100", bus.phase_out); else n_pass++;
    endtask

    task automatic test_op1_mod();
        do_res(3'd0, 2'd0, 14'h0400);
        do_req(3'd0, 2'd1, 3'd0, 3'd0, 10'h000);
        n_total++; if (bus.phase_out !== 10'h200) $display("FAIL op1_mod got %h want 200", bus.phase_out); else n_pass++;
    endtask

    task automatic test_feedback();
        do_res(3'd1, 2'd0, 14'h0400);
        do_res(3'd1, 2'd0, 14'h0400);
        do_req(3'd1, 2'd0, 3'd0, 3'd7, 10'h010);
        n_total++; if (bus.phase_out !== 10'h110) $display("FAIL fb7 got %h want 110", bus.phase_out); else n_pass++;
        do_req(3'd1, 2'd0, 3'd0, 3'd1, 10'h010);
        n_total++; if (bus.phase_out !== 10'h014) $display("FAIL fb1 got %h want 014", bus.phase_out); else n_pass++;
        do_req(3'd1, 2'd0, 3'd0, 3'd0, 10'h010);
        n_total++; if (bus.phase_out !== 10'h010) $display("FAIL fb0 got %h want 010", bus.phase_out); else n_pass++;
    endtask

    task automatic test_algorithms();
        do_res(3'd3, 2'd1, 14'h0100);
        do_res(3'd3, 2'd2, 14'h0200);
        do_req(3'd3, 2'd3, 3'd3, 3'd0, 10'h3FF);
        n_total++; if (bus.phase_out !== 10'h17F) $display("FAIL alg3_wrap got %h want 17f", bus.phase_out); else n_pass++;
        do_req(3'd3, 2'd3, 3'd4, 3'd0, 10'h000);
        n_total++; if (bus.phase_out !== 10'h100) $display("FAIL alg4_op3 got %h want 100", bus.phase_out); else n_pass++;
        do_req(3'd3, 2'd3, 3'd7, 3'd0, 10'h0AB);
        n_total++; if (bus.phase_out !== 10'h0AB) $display("FAIL alg7_op3 got %h want 0ab", bus.phase_out); else n_pass++;
        do_res(3'd3, 2'd0, 14'h3C00);
        do_req(3'd3, 2'd2, 3'd1, 3'd0, 10'h000);
        n_total++; if (bus.phase_out !== 10'h280) $display("FAIL alg1_neg got %h want 280", bus.phase_out); else n_pass++;
        do_req(3'd3, 2'd2, 3'd5, 3'd0, 10'h300);
        n_total++; if (bus.phase_out !== 10'h100) $display("FAIL alg5_neg got %h want 100", bus.phase_out); else n_pass++;
    endtask

    task automatic test_same_cycle();
        bus.res_valid = 1'b1; bus.res_voice = 3'd4; bus.res_op = 2'd0; bus.res_data = 14'h0200;
        bus.req_valid = 1'b1; bus.req_voice = 3'd4; bus.req_op = 2'd1; bus.req_alg = 3'd0;
        bus.req_fb = 3'd0; bus.phase_in = 10'h020;
        tick();
        bus.res_valid = 1'b0;
        bus.req_valid = 1'b0;
        n_total++; if (bus.phase_out !== 10'h020) $display("FAIL same_cycle_old got %h want 020", bus.phase_out); else n_pass++;
        do_req(3'd4, 2'd1, 3'd0, 3'd0, 10'h020);
        n_total++; if (bus.phase_out !== 10'h120) $display("FAIL same_cycle_new got %h want 120", bus.phase_out); else n_pass++;
    endtask

    task automatic test_out_of_range();
        do_req(3'd6, 2'd1, 3'd5, 3'd0, 10'h155);
        n_total++; if (bus.mod_valid !== 1'b1) $display("FAIL oor_valid got %b want 1", bus.mod_valid); else n_pass++;
        n_total++; if (bus.phase_out !== 10'h155) $display("FAIL oor_phase got %h want 155", bus.phase_out); else n_pass++;
    endtask

    task automatic test_clk_en();
        clk_en = 1'b0;
        bus.res_valid = 1'b1; bus.res_voice = 3'd0; bus.res_op = 2'd0; bus.res_data = 14'h0100;
        bus.req_valid = 1'b1; bus.req_voice = 3'd0; bus.req_op = 2'd1; bus.req_alg = 3'd0;
        bus.req_fb = 3'd0; bus.phase_in = 10'h000;
        tick();
        bus.res_valid = 1'b0;
        bus.req_valid = 1'b0;
        n_total++; if (bus.mod_valid !== 1'b0) $display("FAIL clken_valid got %b want 0", bus.mod_valid); else n_pass++;
        n_total++; if (bus.phase_out !== 10'h155) $display("FAIL clken_hold got %h want 155", bus.phase_out); else n_pass++;
        clk_en = 1'b1;
        do_req(3'd0, 2'd1, 3'd0, 3'd0, 10'h000);
        n_total++; if (bus.phase_out !== 10'h200) $display("FAIL clken_nowrite got %h want 200", bus.phase_out); else n_pass++;
    endtask

    task automatic test_accumulator();
`ifdef JT12_OPMOD_ACC_EN
        do_req(3'd5, 2'd0, 3'd7, 3'd0, 10'h000);
        do_res(3'd5, 2'd0, 14'h1FFF);
        do_res(3'd5, 2'd1, 14'h1FFF);
        do_res(3'd5, 2'd2, 14'h1FFF);
        n_total++; if (bus.voice_valid !== 1'b0) $display("FAIL acc_early got %b want 0", bus.voice_valid); else n_pass++;
        do_res(3'd5, 2'd3, 14'h1FFF);
        n_total++; if (bus.voice_valid !== 1'b1) $display("FAIL acc_valid got %b want 1", bus.voice_valid); else n_pass++;
        n_total++; if (bus.voice_out !== 16'sh7FFC) $display("FAIL acc_sum got %h want 7ffc", bus.voice_out); else n_pass++;
        tick();
        n_total++; if (bus.voice_valid !== 1'b0) $display("FAIL acc_pulse got %b want 0", bus.voice_valid); else n_pass++;
        do_res(3'd5, 2'd3, 14'h0010);
        n_total++; if (bus.voice_out !== 16'sh0010) $display("FAIL acc_cleared got %h want 0010", bus.voice_out); else n_pass++;
        do_res(3'd5, 2'd0, 14'h1FFF);
        do_res(3'd5, 2'd0, 14'h1FFF);
        do_res(3'd5, 2'd1, 14'h1FFF);
        do_res(3'd5, 2'd2, 14'h1FFF);
        do_res(3'd5, 2'd3, 14'h1FFF);
        n_total++; if (bus.voice_out !== 16'sh7FFF) $display("FAIL acc_sat got %h want 7fff", bus.voice_out); else n_pass++;
        do_res(3'd2, 2'd1, 14'h0100);
        do_res(3'd2, 2'd3, 14'h0050);
        n_total++; if (bus.voice_out !== 16'sh0050) $display("FAIL acc_alg0 got %h want 0050", bus.voice_out); else n_pass++;
`else
        do_res(3'd5, 2'd1, 14'h1FFF);
        do_res(3'd5, 2'd3, 14'h1FFF);
        n_total++; if (bus.voice_valid !== 1'b0) $display("FAIL noacc_valid got %b want 0", bus.voice_valid); else n_pass++;
        n_total++; if (bus.voice_out !== 16'sh0000) $display("FAIL noacc_out got %h want 0000", bus.voice_out); else n_pass++;
`endif
    endtask

    initial begin
        test_reset();
        test_unmodulated();
        test_op1_mod();
        test_feedback();
        test_algorithms();
        test_same_cycle();
        test_out_of_range();
        test_clk_en();
        test_accumulator();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
